// File: rtl/uart_frame_loader.sv
// uart_frame_loader: assembles 6-byte UART command frames (A5 CMD ADDR DHI DLO CHK),
// verifies the XOR checksum and executes memory writes or CPU start/halt commands.
// Ports: clk, arst_n (async active-low), tick (16x baud strobe), rx_done/rx_data
// (received byte), mem_ready/mem_we/mem_addr/mem_wdata (write handshake),
// cpu_start/cpu_halt/frame_ok/frame_err/overrun (1-cycle pulses),
// err_count (saturating error count), busy (not IDLE).
module uart_frame_loader #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 8,
   parameter int WORD_WIDTH    = 16,
   parameter int TIMEOUT_TICKS = 480
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  tick,
   input  logic                  rx_done,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  mem_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   output logic                  cpu_start,
   output logic                  cpu_halt,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic                  overrun,
   output logic [7:0]            err_count,
   output logic                  busy
);

   localparam logic [DATA_WIDTH-1:0] SYNC   = DATA_WIDTH'(8'hA5);
   localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'h01);
   localparam logic [DATA_WIDTH-1:0] CMD_GO = DATA_WIDTH'(8'h02);
   localparam logic [DATA_WIDTH-1:0] CMD_HL = DATA_WIDTH'(8'h03);
   localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DHI, S_DLO, S_CHK, S_EXEC, S_WRITE
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] dhi_q, dhi_d;
   logic [DATA_WIDTH-1:0] dlo_q, dlo_d;
   logic [DATA_WIDTH-1:0] chk_q, chk_d;
   logic [15:0]           gap_q, gap_d;
   logic [7:0]            err_count_q, err_count_d;
   logic                  mem_we_q, mem_we_d;
   logic                  busy_q, busy_d;
   logic                  start_q, start_d;
   logic                  halt_q, halt_d;
   logic                  ok_q, ok_d;
   logic                  err_q, err_d;
   logic                  ovr_q, ovr_d;
   logic                  in_rx;
   logic                  timeout;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      dhi_d       = dhi_q;
      dlo_d       = dlo_q;
      chk_d       = chk_q;
      gap_d       = gap_q;
      err_count_d = err_count_q;
      start_d     = 1'b0;
      halt_d      = 1'b0;
      ok_d        = 1'b0;
      err_d       = 1'b0;
      ovr_d       = 1'b0;
      timeout     = 1'b0;

      in_rx = (state_q == S_CMD) || (state_q == S_ADDR) ||
              (state_q == S_DHI) || (state_q == S_DLO)  ||
              (state_q == S_CHK);

      // a byte arriving on the timeout tick wins and restarts the gap
      if (in_rx) begin
         if (rx_done) begin
            gap_d = '0;
         end else if (tick) begin
            if (gap_q == GAP_LAST) timeout = 1'b1;
            else                   gap_d = gap_q + 16'd1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (rx_done && rx_data == SYNC) begin
               state_d = S_CMD;
               cmd_d   = '0;
               addr_d  = '0;
               dhi_d   = '0;
               dlo_d   = '0;
               chk_d   = '0;
               gap_d   = '0;
            end
         end
         S_CMD: if (rx_done) begin
            cmd_d   = rx_data;
            chk_d   = chk_q ^ rx_data;
            state_d = S_ADDR;
         end
         S_ADDR: if (rx_done) begin
            addr_d  = rx_data;
            chk_d   = chk_q ^ rx_data;
            state_d = S_DHI;
         end
         S_DHI: if (rx_done) begin
            dhi_d   = rx_data;
            chk_d   = chk_q ^ rx_data;
            state_d = S_DLO;
         end
         S_DLO: if (rx_done) begin
            dlo_d   = rx_data;
            chk_d   = chk_q ^ rx_data;
            state_d = S_CHK;
         end
         S_CHK: if (rx_done) begin
            if (rx_data == chk_q) begin
               state_d = S_EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            ovr_d = rx_done;
            if (cmd_q == CMD_WR) begin
               state_d = S_WRITE;
            end else if (cmd_q == CMD_GO) begin
               start_d = 1'b1;
               ok_d    = 1'b1;
               state_d = S_IDLE;
            end else if (cmd_q == CMD_HL) begin
               halt_d  = 1'b1;
               ok_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            ovr_d = rx_done;
            if (mem_ready) begin
               ok_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (timeout) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end

      if (err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;

      mem_we_d = (state_d == S_WRITE);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         addr_q      <= '0;
         dhi_q       <= '0;
         dlo_q       <= '0;
         chk_q       <= '0;
         gap_q       <= '0;
         err_count_q <= '0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         halt_q      <= 1'b0;
         ok_q        <= 1'b0;
         err_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         dhi_q       <= dhi_d;
         dlo_q       <= dlo_d;
         chk_q       <= chk_d;
         gap_q       <= gap_d;
         err_count_q <= err_count_d;
         mem_we_q    <= mem_we_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         halt_q      <= halt_d;
         ok_q        <= ok_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q[ADDR_WIDTH-1:0];
   assign mem_wdata = {dhi_q, dlo_q};
   assign cpu_start = start_q;
   assign cpu_halt  = halt_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;
   assign overrun   = ovr_q;
   assign err_count = err_count_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: frame-level reference model feeding an event scoreboard;
// a monitor pops expected events whenever the loader pulses an output.
module tb_uart_frame_loader;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        tick = 1'b0;
   logic        rx_done = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        mem_ready = 1'b1;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_start, cpu_halt, frame_ok, frame_err, overrun, busy;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   uart_frame_loader dut (
      .clk(clk), .arst_n(arst_n), .tick(tick),
      .rx_done(rx_done), .rx_data(rx_data),
      .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_start(cpu_start), .cpu_halt(cpu_halt),
      .frame_ok(frame_ok), .frame_err(frame_err),
      .overrun(overrun), .err_count(err_count), .busy(busy)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   localparam int EV_WR = 0, EV_START = 1, EV_HALT = 2, EV_ERR = 3;
   typedef struct {
      int          kind;
      logic [7:0]  addr;
      logic [15:0] data;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] fr[$];
   bit         in_fr = 0;
   int         exp_err = 0;
   int         exp_ovr = 0;
   int         ovr_seen = 0;
   int         we_cycles = 0;

   function automatic void push_ev(int k, logic [7:0] a, logic [15:0] d);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endfunction

   // frame-level view: wait for A5, collect five bytes, then judge the frame
   function automatic void model_byte(logic [7:0] b);
      if (!in_fr) begin
         if (b == 8'hA5) begin
            in_fr = 1;
            fr.delete();
         end
      end else begin
         fr.push_back(b);
         if (fr.size() == 5) begin
            in_fr = 0;
            if ((fr[0] ^ fr[1] ^ fr[2] ^ fr[3]) != fr[4]) push_ev(EV_ERR, 0, 0);
            else if (fr[0] == 8'h01) push_ev(EV_WR, fr[1], {fr[2], fr[3]});
            else if (fr[0] == 8'h02) push_ev(EV_START, 0, 0);
            else if (fr[0] == 8'h03) push_ev(EV_HALT, 0, 0);
            else push_ev(EV_ERR, 0, 0);
         end
      end
   endfunction

   function automatic void model_timeout();
      in_fr = 0;
      fr.delete();
      push_ev(EV_ERR, 0, 0);
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      in_fr = 0;
      fr.delete();
      exp_err = 0;
   endfunction

   // monitor
   initial begin
      logic        hs;
      logic [7:0]  hs_a;
      logic [15:0] hs_d;
      ev_t         e;
      int          k;
      hs = 0; hs_a = 0; hs_d = 0;
      forever begin
         @(negedge clk);
         if (!arst_n) begin
            hs = 0;
         end else begin
            if (frame_err) begin
               chk("err_ev_avail", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("err_ev_kind", e.kind, EV_ERR);
               end
               if (exp_err < 255) exp_err++;
               chk("err_count", 32'(err_count), exp_err);
            end
            if (frame_ok) begin
               k = cpu_start ? EV_START : (cpu_halt ? EV_HALT : EV_WR);
               chk("ok_ev_avail", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("ok_ev_kind", k, e.kind);
                  if (k == EV_WR && e.kind == EV_WR) begin
                     chk("wr_handshake", 32'(hs), 1);
                     chk("wr_addr", 32'(hs_a), 32'(e.addr));
                     chk("wr_data", 32'(hs_d), 32'(e.data));
                  end
               end
            end else if (cpu_start || cpu_halt) begin
               chk("cpu_pulse_has_ok", 32'(frame_ok), 1);
            end
            if (overrun) ovr_seen++;
            if (mem_we) we_cycles++;
            hs   = mem_we && mem_ready;
            hs_a = mem_addr;
            hs_d = mem_wdata;
         end
      end
   end

   // tick every 4th cycle
   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge clk); #1;
         tick = (c == 3);
         c = (c + 1) % 4;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_done = 1'b1;
      rx_data = b;
      model_byte(b);
      @(posedge clk); #1;
      rx_done = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, a, h, l, k,
                             input int gap, input int last_gap);
      send_byte(8'hA5, gap);
      send_byte(c, gap);
      send_byte(a, gap);
      send_byte(h, gap);
      send_byte(l, gap);
      send_byte(k, last_gap);
   endtask

   task automatic quiet(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_cpu_start"}, 32'(cpu_start), 0);
      chk({tag, "_cpu_halt"}, 32'(cpu_halt), 0);
      chk({tag, "_frame_ok"}, 32'(frame_ok), 0);
      chk({tag, "_frame_err"}, 32'(frame_err), 0);
      chk({tag, "_overrun"}, 32'(overrun), 0);
      chk({tag, "_err_count"}, 32'(err_count), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic wait_we(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_we && n < 20);
      chk({tag, "_we_seen"}, 32'(mem_we), 1);
   endtask

   initial begin
      logic [7:0] c, a, h, l, k, g;
      int kd, gp, tk, cyc;
      bit early;

      repeat (3) @(posedge clk); #1;
      check_zero("rst");
      arst_n = 1'b1;
      quiet(2);

      // write frame with minimum latency
      we_cycles = 0;
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 3, 0);
      @(negedge clk);
      chk("t1_exec_we", 32'(mem_we), 0);
      chk("t1_busy", 32'(busy), 1);
      @(negedge clk);
      chk("t1_we", 32'(mem_we), 1);
      chk("t1_addr", 32'(mem_addr), 'h10);
      chk("t1_wdata", 32'(mem_wdata), 'h1234);
      @(negedge clk);
      chk("t1_ok", 32'(frame_ok), 1);
      chk("t1_we_drop", 32'(mem_we), 0);
      chk("t1_busy_low", 32'(busy), 0);
      quiet(3);
      chk("t1_we_cycles", we_cycles, 1);
      chk("t1_errcnt", 32'(err_count), 0);

      // bad checksum
      we_cycles = 0;
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h38, 3, 5);
      chk("t2_we_cycles", we_cycles, 0);
      chk("t2_errcnt", 32'(err_count), 1);

      // start
      send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h02, 3, 0);
      @(negedge clk);
      chk("t3_start_early", 32'(cpu_start), 0);
      @(negedge clk);
      chk("t3_start", 32'(cpu_start), 1);
      chk("t3_ok", 32'(frame_ok), 1);
      quiet(3);

      // stalled write with a byte arriving mid-write
      @(posedge clk); #1;
      mem_ready = 1'b0;
      send_frame(8'h01, 8'h3C, 8'hBE, 8'hEF, 8'h01 ^ 8'h3C ^ 8'hBE ^ 8'hEF, 3, 0);
      wait_we("stall");
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_we", 32'(mem_we), 1);
         chk("stall_addr", 32'(mem_addr), 'h3C);
         chk("stall_wdata", 32'(mem_wdata), 'hBEEF);
         @(posedge clk); #1;
         if (i == 0) begin
            rx_done = 1'b1;
            rx_data = 8'h55;
         end
         if (i == 1) rx_done = 1'b0;
         if (i == 4) mem_ready = 1'b1;
      end
      exp_ovr++;
      quiet(4);
      chk("stall_ovr", ovr_seen, exp_ovr);
      chk("stall_we_done", 32'(mem_we), 0);

      // inter-byte timeout
      send_byte(8'hA5, 3);
      send_byte(8'h01, 0);
      tk = 0; cyc = 0; early = 0;
      while (tk < 480 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (frame_err) early = 1;
         if (tick) tk++;
      end
      chk("to_ticks", tk, 480);
      chk("to_no_early", 32'(early), 0);
      chk("to_busy_before", 32'(busy), 1);
      model_timeout();
      @(negedge clk);
      chk("to_err", 32'(frame_err), 1);
      chk("to_busy_after", 32'(busy), 0);
      send_frame(8'h01, 8'h20, 8'hCA, 8'hFE, 8'h01 ^ 8'h20 ^ 8'hCA ^ 8'hFE, 3, 5);
      chk("to_errcnt", 32'(err_count), 2);

      // leading garbage then halt
      send_byte(8'h00, 3);
      send_byte(8'hFF, 3);
      send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 3, 0);
      @(negedge clk);
      @(negedge clk);
      chk("halt_pulse", 32'(cpu_halt), 1);
      chk("halt_ok", 32'(frame_ok), 1);
      chk("halt_no_err", 32'(frame_err), 0);
      quiet(3);
      chk("halt_errcnt", 32'(err_count), 2);

      // bad command
      send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h07, 3, 5);
      chk("badcmd_errcnt", 32'(err_count), 3);

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         kd = $urandom_range(0, 5);
         gp = $urandom_range(3, 8);
         a = 8'($urandom_range(0, 255));
         h = 8'($urandom_range(0, 255));
         l = 8'($urandom_range(0, 255));
         if (kd == 5) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send_byte(g, gp);
            c = 8'h01;
         end else if (kd < 3) begin
            c = 8'(kd + 1);
         end else if (kd == 3) begin
            c = 8'($urandom_range(1, 3));
         end else begin
            c = 8'($urandom_range(4, 255));
         end
         k = c ^ a ^ h ^ l;
         if (kd == 3) k = k ^ 8'($urandom_range(1, 255));
         send_frame(c, a, h, l, k, gp, gp);
      end
      quiet(10);
      chk("rand_drained", exp_q.size(), 0);

      // saturate the error counter
      for (int f = 0; f < 256; f++) begin
         send_frame(8'h01, 8'(f), 8'h00, 8'h00, 8'h01 ^ 8'(f) ^ 8'h01, 3, 3);
      end
      quiet(5);
      chk("sat_errcnt", 32'(err_count), 255);

      // reset mid-frame
      send_byte(8'hA5, 3);
      send_byte(8'h01, 3);
      send_byte(8'h10, 3);
      @(posedge clk); #1;
      arst_n = 1'b0;
      model_reset();
      #1;
      check_zero("midrst");
      @(posedge clk); #1;
      arst_n = 1'b1;
      quiet(2);
      send_frame(8'h01, 8'h77, 8'h01, 8'h02, 8'h01 ^ 8'h77 ^ 8'h01 ^ 8'h02, 3, 5);
      chk("post_rst_errcnt", 32'(err_count), 0);

      // reset while a write is pending
      @(posedge clk); #1;
      mem_ready = 1'b0;
      send_frame(8'h01, 8'h44, 8'h55, 8'h66, 8'h01 ^ 8'h44 ^ 8'h55 ^ 8'h66, 3, 0);
      wait_we("wrrst");
      #1;
      arst_n = 1'b0;
      model_reset();
      #1;
      chk("wrrst_we", 32'(mem_we), 0);
      chk("wrrst_busy", 32'(busy), 0);
      @(posedge clk); #1;
      arst_n = 1'b1;
      mem_ready = 1'b1;
      quiet(5);

      chk("final_queue", exp_q.size(), 0);
      chk("final_ovr", ovr_seen, exp_ovr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
